// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
// Entry layout and the per-register one-hot mask helper.
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // x0 is hardwired, so it never shows up in a hazard mask.
   function automatic logic [NUM_REGS-1:0] onehot_reg(
      input logic [ADDR_W-1:0] addr
   );
      logic [NUM_REGS-1:0] m;
      m = '0;
      if (addr != '0) m[addr] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries: two pushes, one pop per cycle.
// Entries are exposed oldest-first for hazard and forwarding lookups.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_a,
   input  wb_entry_t        entry_a,
   input  logic             push_b,
   input  wb_entry_t        entry_b,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output wb_entry_t        ordered [DEPTH]
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] n_push;

   assign n_push = CNT_W'(push_a) + CNT_W'(push_b);

   // Pointer and occupancy bookkeeping; entry a lands before entry b.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count  <= count + n_push - CNT_W'(pop);
      end
   end

   // Storage writes; b goes one slot past a when both push.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_a) mem[wr_ptr] <= entry_a;
         if (push_b) mem[wr_ptr + PTR_W'(push_a)] <= entry_b;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_ord
      assign ordered[k] = mem[rd_ptr + PTR_W'(k)];
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: ALU/load arbitration, in-order drain.
// Optional forwarding search enabled by REGFILE_WB_FWD_EN.
module regfile_writeback #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       pending,
   output logic              empty
`ifdef REGFILE_WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   import regfile_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   logic [CNT_W-1:0] count;
   wb_entry_t        ordered [DEPTH];
   wb_entry_t        ld_entry;
   wb_entry_t        alu_entry;
   logic             ld_push;
   logic             alu_push;
   logic             pop;

   assign ld_ready  = (count != FULL);
   assign alu_ready = (count < LAST) || ((count == LAST) && !ld_valid);

   assign ld_push   = ld_valid && ld_ready && (ld_addr != '0);
   assign alu_push  = alu_valid && alu_ready && (alu_addr != '0);
   assign ld_entry  = '{addr: ld_addr, data: ld_data};
   assign alu_entry = '{addr: alu_addr, data: alu_data};
   assign pop       = (count != '0);

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push_a (ld_push),
      .entry_a(ld_entry),
      .push_b (alu_push),
      .entry_b(alu_entry),
      .pop    (pop),
      .count  (count),
      .ordered(ordered)
   );

   // Drain the head into the register-file port every cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
      end else if (pop) begin
         RegWrite  <= 1'b1;
         WriteAddr <= ordered[0].addr;
         WriteData <= ordered[0].data;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Hazard mask over queued entries plus the write in flight.
   always_comb begin
      pending = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < count)
            pending = pending | onehot_reg(ordered[k].addr);
      end
      if (RegWrite) pending = pending | onehot_reg(WriteAddr);
   end

   assign empty = (count == '0) && !RegWrite;

`ifdef REGFILE_WB_FWD_EN
   // Newest match wins: output register, then FIFO oldest to newest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (RegWrite && (WriteAddr == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = WriteData;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count) && (ordered[k].addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = ordered[k].data;
         end
      end
      if (fwd_addr == '0) begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic
// checked against a queue-based model of the write-back path.
module tb_regfile_writeback;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid;
   logic        alu_ready, ld_ready;
   logic [4:0]  alu_addr, ld_addr;
   logic [31:0] alu_data, ld_data;
   logic        RegWrite;
   logic [4:0]  WriteAddr;
   logic [31:0] WriteData;
   logic [31:0] pending;
   logic        empty;
`ifdef REGFILE_WB_FWD_EN
   logic [4:0]  fwd_addr = 5'd0;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int errors = 0;
   int checks = 0;

   logic [4:0]  qa [$];
   logic [31:0] qd [$];
   logic        m_rw;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   regfile_writeback #(.DEPTH(D)) dut (
      .clock    (clock),
      .reset    (reset),
      .alu_valid(alu_valid),
      .alu_ready(alu_ready),
      .alu_addr (alu_addr),
      .alu_data (alu_data),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .RegWrite (RegWrite),
      .WriteAddr(WriteAddr),
      .WriteData(WriteData),
      .pending  (pending),
      .empty    (empty)
`ifdef REGFILE_WB_FWD_EN
      ,
      .fwd_addr (fwd_addr),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] m_pend();
      logic [31:0] m;
      m = '0;
      foreach (qa[i]) m[qa[i]] = 1'b1;
      if (m_rw) m[m_wa] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   function automatic logic m_ldr();
      return qa.size() < D;
   endfunction

   function automatic logic m_alr();
      return (qa.size() <= D - 2) || ((qa.size() < D) && !ld_valid);
   endfunction

   task automatic idle();
      ld_valid  = 1'b0;
      alu_valid = 1'b0;
      ld_addr   = '0;
      alu_addr  = '0;
      ld_data   = '0;
      alu_data  = '0;
   endtask

   task automatic m_reset();
      qa.delete();
      qd.delete();
      m_rw = 1'b0;
      m_wa = '0;
      m_wd = '0;
   endtask

   // One rising edge for both DUT and model; leaves time at edge+1.
   task automatic step();
      logic lt, at;
      lt = ld_valid && m_ldr();
      at = alu_valid && m_alr();
      @(posedge clock);
      if (qa.size() > 0) begin
         m_rw = 1'b1;
         m_wa = qa.pop_front();
         m_wd = qd.pop_front();
      end else begin
         m_rw = 1'b0;
      end
      if (lt && ld_addr != 0) begin
         qa.push_back(ld_addr);
         qd.push_back(ld_data);
      end
      if (at && alu_addr != 0) begin
         qa.push_back(alu_addr);
         qd.push_back(alu_data);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      m_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (RegWrite !== 1'b0 || WriteAddr !== 5'd0 || WriteData !== 32'd0) begin
         errors++;
         $display("FAIL reset_out: got %b/%0d/%h want 0/0/0",
                  RegWrite, WriteAddr, WriteData);
      end
      checks++;
      if (pending !== 32'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: pending=%h empty=%b want 0/1",
                  pending, empty);
      end
      checks++;
      if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: ld=%b alu=%b want 1/1",
                  ld_ready, alu_ready);
      end
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      // Queue three entries, then reset asynchronously mid-cycle.
      ld_valid = 1; ld_addr = 5'd1; ld_data = 32'hA1;
      alu_valid = 1; alu_addr = 5'd2; alu_data = 32'hA2;
      step();
      ld_addr = 5'd3; ld_data = 32'hA3;
      alu_addr = 5'd6; alu_data = 32'hA6;
      step();
      idle();
      #2 reset = 1'b0;
      m_reset();
      #1;
      checks++;
      if (RegWrite !== 1'b0 || pending !== 32'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: rw=%b pending=%h empty=%b want 0/0/1",
                  RegWrite, pending, empty);
      end
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (RegWrite !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: cycle %0d rw=%b empty=%b want 0/1",
                     i, RegWrite, empty);
         end
      end
   endtask

   task automatic test_single();
      idle();
      alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: alu_ready=%b want 1", alu_ready);
      end
      step();
      idle();
      checks++;
      if (RegWrite !== 1'b0 || pending[5] !== 1'b1) begin
         errors++;
         $display("FAIL single_n: rw=%b pend5=%b want 0/1",
                  RegWrite, pending[5]);
      end
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== 5'd5 ||
          WriteData !== 32'hDEADBEEF || pending[5] !== 1'b1) begin
         errors++;
         $display("FAIL single_write: got %b/%0d/%h p5=%b want 1/5/deadbeef/1",
                  RegWrite, WriteAddr, WriteData, pending[5]);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0 || pending !== 32'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL single_done: rw=%b pending=%h empty=%b want 0/0/1",
                  RegWrite, pending, empty);
      end
   endtask

   task automatic test_dual();
      idle();
      ld_valid = 1; ld_addr = 5'd3; ld_data = 32'h11;
      alu_valid = 1; alu_addr = 5'd4; alu_data = 32'h22;
      #1;
      checks++;
      if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL dual_ready: ld=%b alu=%b want 1/1", ld_ready, alu_ready);
      end
      step();
      idle();
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== 5'd3 || WriteData !== 32'h11) begin
         errors++;
         $display("FAIL dual_first: got %b/%0d/%h want 1/3/11",
                  RegWrite, WriteAddr, WriteData);
      end
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== 5'd4 || WriteData !== 32'h22) begin
         errors++;
         $display("FAIL dual_second: got %b/%0d/%h want 1/4/22",
                  RegWrite, WriteAddr, WriteData);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL dual_end: rw=%b want 0", RegWrite);
      end
   endtask

   task automatic test_priority();
      logic [4:0] seen [$];
      logic [4:0] want [6];
      want = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
      idle();
      ld_valid = 1; ld_addr = 5'd10; ld_data = 32'h100;
      alu_valid = 1; alu_addr = 5'd11; alu_data = 32'h110;
      step();
      if (RegWrite) seen.push_back(WriteAddr);
      ld_addr = 5'd12; ld_data = 32'h120;
      alu_addr = 5'd13; alu_data = 32'h130;
      step();
      if (RegWrite) seen.push_back(WriteAddr);
      ld_addr = 5'd14; ld_data = 32'h140;
      alu_addr = 5'd15; alu_data = 32'h150;
      #1;
      checks++;
      if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
         errors++;
         $display("FAIL prio_ready: ld=%b alu=%b want 1/0", ld_ready, alu_ready);
      end
      step();
      if (RegWrite) seen.push_back(WriteAddr);
      ld_valid = 0;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio_retry: alu_ready=%b want 1", alu_ready);
      end
      step();
      if (RegWrite) seen.push_back(WriteAddr);
      idle();
      for (int i = 0; i < 6; i++) begin
         step();
         if (RegWrite) seen.push_back(WriteAddr);
      end
      checks++;
      if (seen.size() != 6) begin
         errors++;
         $display("FAIL prio_count: writes=%0d want 6", seen.size());
      end
      for (int i = 0; i < 6 && i < seen.size(); i++) begin
         checks++;
         if (seen[i] !== want[i]) begin
            errors++;
            $display("FAIL prio_order: write %0d addr=%0d want %0d",
                     i, seen[i], want[i]);
         end
      end
   endtask

   task automatic test_addr0();
      idle();
      alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL addr0_ready: alu_ready=%b want 1", alu_ready);
      end
      step();
      idle();
      checks++;
      if (empty !== 1'b1 || pending !== 32'd0 || RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL addr0_noq: empty=%b pending=%h rw=%b want 1/0/0",
                  empty, pending, RegWrite);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL addr0_nowrite: rw=%b want 0", RegWrite);
      end
      // Address 0 alongside a real load: only the load is queued.
      ld_valid = 1; ld_addr = 5'd9; ld_data = 32'h99;
      alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
      step();
      idle();
      checks++;
      if (pending !== 32'h0000_0200) begin
         errors++;
         $display("FAIL addr0_mix_pend: pending=%h want 00000200", pending);
      end
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== 5'd9 || WriteData !== 32'h99) begin
         errors++;
         $display("FAIL addr0_mix_wr: got %b/%0d/%h want 1/9/99",
                  RegWrite, WriteAddr, WriteData);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL addr0_mix_end: rw=%b empty=%b want 0/1", RegWrite, empty);
      end
   endtask

`ifdef REGFILE_WB_FWD_EN
   task automatic test_fwd();
      idle();
      ld_valid = 1; ld_addr = 5'd7; ld_data = 32'h1;
      alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h2;
      step();
      idle();
      fwd_addr = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin
            errors++;
            $display("FAIL fwd_newest: cycle %0d hit=%b data=%h want 1/2",
                     i, fwd_hit, fwd_data);
         end
         step();
      end
      fwd_addr = 5'd0;
      #1;
      checks++;
      if (fwd_hit !== 1'b0) begin
         errors++;
         $display("FAIL fwd_zero: hit=%b want 0", fwd_hit);
      end
      step();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         ld_valid  = ($urandom_range(0, 9) < 6);
         alu_valid = ($urandom_range(0, 9) < 6);
         ld_addr   = 5'($urandom_range(0, 31));
         alu_addr  = 5'($urandom_range(0, 31));
         ld_data   = $urandom;
         alu_data  = $urandom;
`ifdef REGFILE_WB_FWD_EN
         fwd_addr  = 5'($urandom_range(0, 31));
`endif
         #1;
         checks++;
         if (ld_ready !== m_ldr() || alu_ready !== m_alr()) begin
            errors++;
            $display("FAIL rnd_ready: cycle %0d ld=%b alu=%b want %b/%b",
                     c, ld_ready, alu_ready, m_ldr(), m_alr());
         end
`ifdef REGFILE_WB_FWD_EN
         begin
            logic        eh;
            logic [31:0] ed;
            eh = 1'b0;
            ed = '0;
            if (fwd_addr != 0) begin
               for (int i = qa.size() - 1; i >= 0 && !eh; i--) begin
                  if (qa[i] == fwd_addr) begin
                     eh = 1'b1;
                     ed = qd[i];
                  end
               end
               if (!eh && m_rw && m_wa == fwd_addr) begin
                  eh = 1'b1;
                  ed = m_wd;
               end
            end
            checks++;
            if (fwd_hit !== eh || (eh && fwd_data !== ed)) begin
               errors++;
               $display("FAIL rnd_fwd: cycle %0d hit=%b data=%h want %b/%h",
                        c, fwd_hit, fwd_data, eh, ed);
            end
         end
`endif
         step();
         checks++;
         if (RegWrite !== m_rw || WriteAddr !== m_wa || WriteData !== m_wd) begin
            errors++;
            $display("FAIL rnd_write: cycle %0d got %b/%0d/%h want %b/%0d/%h",
                     c, RegWrite, WriteAddr, WriteData, m_rw, m_wa, m_wd);
         end
         checks++;
         if (pending !== m_pend() ||
             empty !== (qa.size() == 0 && !m_rw)) begin
            errors++;
            $display("FAIL rnd_status: cycle %0d pending=%h empty=%b want %h/%b",
                     c, pending, empty, m_pend(), (qa.size() == 0 && !m_rw));
         end
      end
      idle();
      repeat (D + 2) step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_priority();
      test_addr0();
`ifdef REGFILE_WB_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
